// File: rtl/cache_axi_bridge.sv
// Cache miss-path to AXI4 master bridge.
// An independent read engine (R_IDLE/R_AR/R_DATA) and write engine
// (W_IDLE/W_AW/W_DATA/W_B) share only the read-after-write line hazard.
// Handshakes: on every AXI channel a transfer happens on a rising edge where
// valid and ready are both high; the sender holds valid and its payload
// stable until that edge. On the cache side rd_req is held until the edge
// where rd_rdy is high, and wr_req is a one-cycle pulse only legal while
// wr_rdy is high.
module cache_axi_bridge #(
    parameter logic [3:0] AXI_ID     = 4'd1,
    parameter int         LINE_BEATS = 4
) (
    input  logic         clk,
    input  logic         resetn,
    // cache read side
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    // cache write side
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    // AXI read address / data
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    // AXI write address / data / response
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_B    = 2'd3;

    localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

    // Request type to AXI burst length: only line transfers are bursts.
    function automatic logic [7:0] map_len(input logic [2:0] t);
        return t[2] ? LINE_LEN : 8'd0;
    endfunction

    // Request type to AXI beat size (log2 bytes).
    function automatic logic [2:0] map_size(input logic [2:0] t);
        logic [2:0] s;
        if (t[2] || t[1:0] == 2'b10) s = 3'd2;
        else if (t[1:0] == 2'b01)    s = 3'd1;
        else                         s = 3'd0;
        return s;
    endfunction

    // Line transfers start at the line base; uncached accesses keep their address.
    function automatic logic [31:0] map_addr(input logic [2:0] t, input logic [31:0] a);
        return t[2] ? {a[31:4], 4'b0} : a;
    endfunction

    logic [1:0]   r_state;
    logic [31:0]  ar_addr_q;
    logic [7:0]   ar_len_q;
    logic [2:0]   ar_size_q;

    logic [1:0]   w_state;
    logic [31:0]  w_addr_q;
    logic [7:0]   w_len_q;
    logic [2:0]   w_size_q;
    logic [3:0]   w_strb_q;
    logic [127:0] w_data_q;
    logic [7:0]   beat_q;

    logic         wr_accept;
    logic         rd_accept;
    logic         hazard;
    logic [1:0]   word_idx;
    logic         unused_ok;

    // A write captured this same cycle counts as in flight, so a read to its line waits.
    assign wr_accept = wr_req & wr_rdy;
    assign hazard    = ((w_state != W_IDLE) && (rd_addr[31:4] == w_addr_q[31:4]))
                     | (wr_accept && (rd_addr[31:4] == wr_addr[31:4]));
    assign rd_rdy    = (r_state == R_IDLE) & ~hazard;
    assign rd_accept = rd_req & rd_rdy;

    // Read engine: latch the request, issue AR, stream R beats back to the cache.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= R_IDLE;
            ar_addr_q <= 32'd0;
            ar_len_q  <= 8'd0;
            ar_size_q <= 3'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_accept) begin
                        ar_addr_q <= map_addr(rd_type, rd_addr);
                        ar_len_q  <= map_len(rd_type);
                        ar_size_q <= map_size(rd_type);
                        r_state   <= R_AR;
                    end
                end
                R_AR:    if (arready) r_state <= R_DATA;
                R_DATA:  if (rvalid && rlast) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign arid      = AXI_ID;
    assign araddr    = ar_addr_q;
    assign arlen     = ar_len_q;
    assign arsize    = ar_size_q;
    assign arburst   = 2'b01;
    assign arvalid   = (r_state == R_AR);
    assign rready    = (r_state == R_DATA);
    assign ret_valid = rready & rvalid;
    assign ret_last  = ret_valid & rlast;
    assign ret_data  = rdata;

    assign wr_rdy = (w_state == W_IDLE);

    // Write engine: capture the whole request, then AW, W beats, and wait for B.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state  <= W_IDLE;
            w_addr_q <= 32'd0;
            w_len_q  <= 8'd0;
            w_size_q <= 3'd0;
            w_strb_q <= 4'd0;
            w_data_q <= 128'd0;
            beat_q   <= 8'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_req) begin
                        w_addr_q <= map_addr(wr_type, wr_addr);
                        w_len_q  <= map_len(wr_type);
                        w_size_q <= map_size(wr_type);
                        w_strb_q <= wr_type[2] ? 4'hf : wr_wstrb;
                        w_data_q <= wr_data;
                        beat_q   <= 8'd0;
                        w_state  <= W_AW;
                    end
                end
                W_AW: if (awready) w_state <= W_DATA;
                W_DATA: begin
                    if (wready) begin
                        if (beat_q == w_len_q) w_state <= W_B;
                        else                   beat_q  <= beat_q + 8'd1;
                    end
                end
                W_B:     if (bvalid) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Line addresses are forced to word 0, so one adder covers both the line
    // beat walk and the single uncached word selected by addr[3:2].
    assign word_idx = w_addr_q[3:2] + beat_q[1:0];

    assign awid    = AXI_ID;
    assign awaddr  = w_addr_q;
    assign awlen   = w_len_q;
    assign awsize  = w_size_q;
    assign awburst = 2'b01;
    assign awvalid = (w_state == W_AW);
    assign wvalid  = (w_state == W_DATA);
    assign wdata   = w_data_q[{word_idx, 5'd0} +: 32];
    assign wstrb   = w_strb_q;
    assign wlast   = wvalid & (beat_q == w_len_q);
    assign bready  = (w_state == W_B);

    // Response ids and status carry no information for this bridge.
    assign unused_ok = ^{rid, rresp, bid, bresp};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: AXI slave responders, a
// scoreboard of expected AR/R/AW/W traffic, and a cycle model of rd_rdy/wr_rdy.
`timescale 1ns/1ps
module tb_cache_axi_bridge;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [3:0]   arid, awid, rid, bid;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    cache_axi_bridge u_dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [42:0] exp_ar_q[$];   // {araddr, arlen, arsize}
    logic [32:0] exp_ret_q[$];  // {ret_last, ret_data}
    logic [42:0] exp_aw_q[$];   // {awaddr, awlen, awsize}
    logic [36:0] exp_w_q[$];    // {wdata, wstrb, wlast}
    logic [31:0] r_data_q[$];   // memory data the R responder returns

    int n_checks = 0;
    int n_fail   = 0;

    int ar_delay = 0, aw_delay = 0, b_delay = 0;
    int abort_beat = -1;
    logic abort_flag;
    int ar_cnt = 0;
    int ar_len_arr[1024];
    int w_last_cnt = 0;
    int b_sent = 0;
    int ar_hs_cyc = 0, b_hs_cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [2:0] t, input logic [31:0] a);
        return (t == 3'b100) ? (a & 32'hFFFF_FFF0) : a;
    endfunction

    function automatic logic [7:0] exp_len(input logic [2:0] t);
        return (t == 3'b100) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] exp_size(input logic [2:0] t);
        case (t)
            3'b100, 3'b010: return 3'd2;
            3'b001:         return 3'd1;
            default:        return 3'd0;
        endcase
    endfunction

    // ---------------- AXI slave responders ----------------
    initial begin
        arready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (arvalid) begin
                repeat (ar_delay) begin @(posedge clk); #1; end
                arready = 1'b1;
                ar_len_arr[ar_cnt % 1024] = int'(arlen);
                @(posedge clk); #1;
                arready = 1'b0;
                ar_cnt++;
            end
        end
    end

    initial begin
        int r_idx;
        int len;
        r_idx = 0;
        rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rid = 4'd1; rresp = 2'd0;
        abort_flag = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (r_idx < ar_cnt) begin
                len = ar_len_arr[r_idx % 1024];
                r_idx++;
                for (int i = 0; i <= len; i++) begin
                    rvalid = 1'b1;
                    rdata  = (r_data_q.size() > 0) ? r_data_q.pop_front() : 32'hDEAD_BEEF;
                    rlast  = (i == len);
                    if (i == abort_beat) abort_flag = 1'b1;
                    @(posedge clk); #1;
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                    if (abort_flag) begin
                        abort_flag = 1'b0;
                        break;
                    end
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
            end
        end
    end

    initial begin
        awready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin
                repeat (aw_delay) begin @(posedge clk); #1; end
                awready = 1'b1;
                @(posedge clk); #1;
                awready = 1'b0;
            end
        end
    end

    initial begin
        wready = 1'b0;
        forever begin
            @(posedge clk); #1;
            wready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        bvalid = 1'b0; bid = 4'd1; bresp = 2'd0;
        forever begin
            @(posedge clk); #1;
            if (b_sent < w_last_cnt) begin
                repeat (b_delay) begin @(posedge clk); #1; end
                bvalid = 1'b1;
                @(posedge clk); #1;
                bvalid = 1'b0;
                b_sent++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        m_r_busy = 1'b0, m_w_busy = 1'b0;
    logic [27:0] m_w_line = 28'd0;
    logic        ar_wait = 1'b0, aw_wait = 1'b0;
    logic [42:0] ar_hold, aw_hold;

    always @(negedge clk) begin
        logic exp_hazard;
        logic [42:0] e43;
        logic [36:0] e37;
        logic [32:0] e33;
        if (!resetn) begin
            m_r_busy = 1'b0; m_w_busy = 1'b0; ar_wait = 1'b0; aw_wait = 1'b0;
        end else begin
            exp_hazard = (m_w_busy && rd_addr[31:4] == m_w_line)
                       || (wr_req && !m_w_busy && rd_addr[31:4] == wr_addr[31:4]);
            check_eq("rd_rdy", rd_rdy, !m_r_busy && !exp_hazard);
            check_eq("wr_rdy", wr_rdy, !m_w_busy);
            check_eq("ret_last_without_valid", ret_last & ~ret_valid, 1'b0);

            if (ar_wait) begin
                check_eq("arvalid_held", arvalid, 1'b1);
                check_eq("ar_stable", {araddr, arlen, arsize}, ar_hold);
            end
            ar_wait = arvalid && !arready;
            ar_hold = {araddr, arlen, arsize};
            if (arvalid && arready) begin
                ar_hs_cyc = cyc;
                check_eq("ar_id_burst", {arid, arburst}, {4'd1, 2'b01});
                if (exp_ar_q.size() == 0) check_eq("ar_unexpected", 1'b1, 1'b0);
                else begin
                    e43 = exp_ar_q.pop_front();
                    check_eq("ar_fields", {araddr, arlen, arsize}, e43);
                end
            end

            if (ret_valid) begin
                if (exp_ret_q.size() == 0) check_eq("ret_unexpected", 1'b1, 1'b0);
                else begin
                    e33 = exp_ret_q.pop_front();
                    check_eq("ret_last_data", {ret_last, ret_data}, e33);
                end
            end

            if (aw_wait) begin
                check_eq("awvalid_held", awvalid, 1'b1);
                check_eq("aw_stable", {awaddr, awlen, awsize}, aw_hold);
            end
            aw_wait = awvalid && !awready;
            aw_hold = {awaddr, awlen, awsize};
            if (awvalid && awready) begin
                check_eq("aw_id_burst", {awid, awburst}, {4'd1, 2'b01});
                if (exp_aw_q.size() == 0) check_eq("aw_unexpected", 1'b1, 1'b0);
                else begin
                    e43 = exp_aw_q.pop_front();
                    check_eq("aw_fields", {awaddr, awlen, awsize}, e43);
                end
            end

            if (wvalid && wready) begin
                if (exp_w_q.size() == 0) check_eq("w_unexpected", 1'b1, 1'b0);
                else begin
                    e37 = exp_w_q.pop_front();
                    check_eq("w_beat", {wdata, wstrb, wlast}, e37);
                end
                if (wlast) w_last_cnt++;
            end

            if (bvalid && bready) b_hs_cyc = cyc;

            if (rd_req && rd_rdy) m_r_busy = 1'b1;
            if (ret_last)         m_r_busy = 1'b0;
            if (bvalid && bready) m_w_busy = 1'b0;
            if (wr_req && wr_rdy) begin
                m_w_busy = 1'b1;
                m_w_line = wr_addr[31:4];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_read(input logic [2:0] t, input logic [31:0] a, input logic [31:0] base,
                              input bit do_push, output int waited);
        int n;
        n = 0;
        if (do_push) begin
            exp_ar_q.push_back({exp_addr(t, a), exp_len(t), exp_size(t)});
            for (int i = 0; i <= int'(exp_len(t)); i++) begin
                r_data_q.push_back(base + 32'(i));
                exp_ret_q.push_back({(i == int'(exp_len(t))), base + 32'(i)});
            end
        end
        rd_req = 1'b1; rd_type = t; rd_addr = a;
        @(negedge clk);
        while (!rd_rdy && n < 500) begin @(negedge clk); n++; end
        if (!rd_rdy) check_eq("rd_accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        rd_req = 1'b0;
        waited = n;
    endtask

    task automatic drive_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                               input logic [127:0] d);
        int n;
        int idx;
        n = 0;
        idx = int'(a[3:2]);
        exp_aw_q.push_back({exp_addr(t, a), exp_len(t), exp_size(t)});
        if (t == 3'b100) begin
            for (int i = 0; i < 4; i++) exp_w_q.push_back({d[32*i +: 32], 4'hf, (i == 3)});
        end else begin
            exp_w_q.push_back({d[32*idx +: 32], s, 1'b1});
        end
        while (!wr_rdy && n < 500) begin @(posedge clk); #1; n++; end
        if (!wr_rdy) check_eq("wr_rdy_timeout", 1'b0, 1'b1);
        wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_ar_q.size() != 0 || exp_ret_q.size() != 0 || exp_aw_q.size() != 0 ||
                exp_w_q.size() != 0 || !wr_rdy) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 2000) check_eq("idle_timeout", 64'(n), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic wait_bready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bready && n < 500) begin @(negedge clk); n++; end
        if (!bready) check_eq("bready_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rd_rdy"}, rd_rdy, 1'b1);
        check_eq({tag, "_wr_rdy"}, wr_rdy, 1'b1);
        check_eq({tag, "_valids"}, {ret_valid, ret_last, arvalid, rready, awvalid, wvalid, wlast, bready}, 8'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] types[4];

    initial begin
        int w0, w1;
        int n;
        types = '{3'b000, 3'b001, 3'b010, 3'b100};
        resetn = 1'b0;
        rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'd0;
        wr_req = 1'b0; wr_type = 3'd0; wr_addr = 32'd0; wr_wstrb = 4'd0; wr_data = 128'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // line read, 4-beat refill
        drive_read(3'b100, 32'h1C00_0014, 32'h0000_00A0, 1'b1, w0);
        wait_idle();

        // line write with delayed awready
        aw_delay = 3; b_delay = 2;
        drive_write(3'b100, 32'h0000_1230, 4'h0, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        wait_idle();
        aw_delay = 0;

        // uncached store of word 2
        drive_write(3'b010, 32'hBFAF_8008, 4'h3, {32'hCAFE_0003, 32'h1234_5678, 32'hCAFE_0001, 32'hCAFE_0000});
        wait_idle();

        // uncached half and byte reads
        drive_read(3'b001, 32'h8000_0002, 32'h0000_5555, 1'b1, w0);
        wait_idle();
        drive_read(3'b000, 32'h8000_0003, 32'h0000_0077, 1'b1, w0);
        wait_idle();

        // read to the line of a write waiting in W_B
        b_delay = 6;
        drive_write(3'b100, 32'h0000_2000, 4'h0, {32'h4, 32'h3, 32'h2, 32'h1});
        wait_bready();
        drive_read(3'b010, 32'h0000_2004, 32'h0000_00C0, 1'b1, w0);
        check_eq("hazard_blocked", (w0 > 0), 1'b1);
        wait_idle();
        check_eq("hazard_ar_after_b", (ar_hs_cyc > b_hs_cyc), 1'b1);

        // read to another line while the write waits in W_B
        drive_write(3'b100, 32'h0000_2000, 4'h0, {32'h8, 32'h7, 32'h6, 32'h5});
        wait_bready();
        drive_read(3'b010, 32'h0000_3000, 32'h0000_00C8, 1'b1, w0);
        check_eq("no_hazard_immediate", 64'(w0), 64'd0);
        wait_idle();

        // same-cycle write and read, same line
        b_delay = 3;
        fork
            drive_write(3'b100, 32'h0000_0040, 4'h0, {32'h44, 32'h43, 32'h42, 32'h41});
            drive_read(3'b010, 32'h0000_0048, 32'h0000_0F00, 1'b1, w1);
        join
        check_eq("same_cycle_same_line_blocked", (w1 > 0), 1'b1);
        wait_idle();
        check_eq("same_cycle_ar_after_b", (ar_hs_cyc > b_hs_cyc), 1'b1);

        // same-cycle write and read, different lines
        fork
            drive_write(3'b100, 32'h0000_0040, 4'h0, {32'h54, 32'h53, 32'h52, 32'h51});
            drive_read(3'b100, 32'h0000_1000, 32'h0000_0E00, 1'b1, w1);
        join
        check_eq("same_cycle_diff_line_accepted", 64'(w1), 64'd0);
        wait_idle();

        // reset during the third beat of a line read
        abort_beat = 2;
        exp_ar_q.push_back({32'h0000_0100, 8'd3, 3'd2});
        r_data_q.push_back(32'hB0); r_data_q.push_back(32'hB1); r_data_q.push_back(32'hB2);
        exp_ret_q.push_back({1'b0, 32'hB0}); exp_ret_q.push_back({1'b0, 32'hB1});
        drive_read(3'b100, 32'h0000_0108, 32'h0, 1'b0, w0);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!abort_flag && n < 200);
        check_eq("abort_beat_reached", abort_flag, 1'b1);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        abort_beat = -1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        check_eq("mid_reset_ret_drained", 64'(exp_ret_q.size()), 64'd0);
        @(posedge clk); #1;
        drive_read(3'b100, 32'h0000_0100, 32'h0000_00E0, 1'b1, w0);
        wait_idle();

        // random mix of reads and writes, sometimes together
        for (int k = 0; k < 10; k++) begin
            ar_delay = $urandom_range(0, 2);
            aw_delay = $urandom_range(0, 2);
            b_delay  = $urandom_range(0, 3);
            fork
                if (k % 3 != 1)
                    drive_write(types[$urandom_range(0, 3)], {20'h00040, 7'd0, 5'($urandom_range(0, 31))},
                                4'($urandom_range(1, 15)),
                                {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});
                if (k % 3 != 0)
                    drive_read(types[$urandom_range(0, 3)], {20'h00040, 7'd0, 5'($urandom_range(0, 31))},
                               32'($urandom), 1'b1, w1);
            join
            wait_idle();
        end

        check_eq("end_ar_q_empty",  64'(exp_ar_q.size()),  64'd0);
        check_eq("end_ret_q_empty", 64'(exp_ret_q.size()), 64'd0);
        check_eq("end_aw_q_empty",  64'(exp_aw_q.size()),  64'd0);
        check_eq("end_w_q_empty",   64'(exp_w_q.size()),   64'd0);
        check_eq("end_rdata_used",  64'(r_data_q.size()),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
